cache_controller: RTL and testbench
===================================

Name: cache_controller

Overview:
- Two-way set-associative read cache between the MEM stage and the SRAM controller.
- Serves MEM-stage loads from on-chip storage on a hit with zero extra latency.
- On a miss, fetches the full 64-bit block (two words) from the SRAM controller.
- Stores are write-through and no-write-allocate. `ready` stalls the pipeline while an SRAM transaction is outstanding.

Parameters:
- BASE_ADDR, 1024: data-memory base, subtracted from `address` before decoding.
- INDEX_BITS, 6: set index width (64 sets).
- TAG_BITS, 10: tag width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- rd_en  in  1  MEM-stage load request
- wr_en  in  1  MEM-stage store request
- address  in  32  byte address, word aligned
- wdata  in  32  store data
- rdata  out  32  load data
- ready  out  1  0 = stall pipeline
- sram_rd_en  out  1  block read request to SRAM controller
- sram_wr_en  out  1  word write request to SRAM controller
- sram_address  out  32  equals `address` (unmodified, base included)
- sram_wdata  out  32  equals `wdata`
- sram_rdata  in  64  fetched block; word0 in [31:0], word1 in [63:32]
- sram_ready  in  1  SRAM controller ready

Behaviour:
- **Address split:** a = address - BASE_ADDR.
  - offset = a[2]
  - index = a[8:3]
  - tag = a[18:9]
  - a[1:0] ignored.
- **Storage:** per set, per way: valid (1), tag (10), data (64). One LRU bit per set; LRU=0 means way0 is least recently used.
- **Hit:** the set is valid in way w and the tag matches. rdata = the selected word of way w. Tag compare and word select are combinational.
- **FSM states:** IDLE, RD_MISS, WR. The state is registered; all outputs are combinational from state and inputs.
- **IDLE:**
  - wr_en=1 -> WR. wr_en has priority over rd_en.
  - Else rd_en=1 and hit -> ready=1 and rdata valid in the same cycle. LRU[index] is updated to point at the other way at the clock edge. Stay in IDLE.
  - Else rd_en=1 and miss -> ready=0, go to RD_MISS.
  - No request -> ready=1, rdata=0.
- **RD_MISS:**
  - sram_rd_en=1 and ready=0 while sram_ready=0.
  - On the first cycle with sram_ready=1:
    - ready=1 and rdata = selected word of sram_rdata, bypassed combinationally.
    - At the clock edge, write the block, tag and valid=1 into the victim way, update LRU, and go to IDLE.
    - sram_rd_en drops the cycle after, so the SRAM controller never restarts.
  - The cycle of entry into RD_MISS never completes. The SRAM controller drives ready=0 from its idle state when enabled.
- **Victim way:** way0 if invalid, else way1 if invalid, else the LRU way.
- **WR:**
  - sram_wr_en=1 and ready=0 until sram_ready=1. In that cycle ready=1, then go to IDLE.
  - On a hit, the addressed 32-bit word of the hit way is overwritten with wdata at that edge and LRU is updated.
  - On a miss, no cache state changes.
- **Request stability:** rd_en, wr_en, address and wdata are held stable by the pipeline while ready=0. The block does not re-sample them.
- **Reset:** all valid bits=0, all LRU bits=0, state=IDLE.
  - Outputs during reset: ready=1, sram_rd_en=0, sram_wr_en=0, rdata=0.
  - Reset mid-transaction abandons it; no partial fill is written.
- **Data array:** not reset.

Decomposition:
- **Shared package:** BASE_ADDR, field widths and bit positions (offset bit 2, index [8:3], tag [18:9]), FSM state encoding (2-bit).
- **Sub-module cache_memory:** owns the valid/tag/data arrays and LRU bits. It provides:
  - combinational lookup: hit, hit_way, word out;
  - synchronous fill and word-update ports;
  - LRU update.
- **cache_controller:** holds the FSM and the SRAM handshake.

Test Plan:
- **Cold miss:** after reset, rd_en at 1024 with the SRAM model returning 0x0000_0022_0000_0011 after 5 cycles.
  - ready=0 with sram_rd_en=1, sram_address=1024.
  - On sram_ready: rdata=0x11, ready=1.
  - Next cycle: rd_en at 1028 hits with zero latency, rdata=0x22, no SRAM request.
- **Way fill and eviction:** read misses at 1024, then 1536 (same index 0, tags 0 and 1) fill way0 and way1.
  - Read 1024 again (hit, way1 becomes LRU).
  - Read 2048 (tag 2) evicts way1.
  - Re-read 1024 hits; 1536 misses.
- **Write hit:** after 1024 is cached, wr_en at 1028 with wdata=0xDEAD_BEEF.
  - sram_wr_en=1 until sram_ready, ready=0 meanwhile.
  - A subsequent read of 1028 hits and returns 0xDEAD_BEEF.
- **Write miss (no allocate):** wr_en at 4096 completes through SRAM; a following read of 4096 misses (sram_rd_en=1).
- **Simultaneous rd_en and wr_en:** at 1024, the cycle is handled as a write (sram_wr_en=1, sram_rd_en=0).
- **Reset mid-miss:** assert rst 2 cycles into RD_MISS.
  - Next cycle: state IDLE, sram_rd_en=0, ready=1.
  - A later read of the same address misses (valid was never set).

Source files
------------

// File: rtl/cache_controller_pkg.sv
// Shared definitions for the two-way read cache: address field layout, default
// geometry and the controller state encoding.
package cache_controller_pkg;

    localparam logic [31:0] DEF_BASE_ADDR  = 32'd1024;
    localparam int          DEF_INDEX_BITS = 6;
    localparam int          DEF_TAG_BITS   = 10;

    localparam int OFFSET_BIT = 2;
    localparam int INDEX_LSB  = 3;
    localparam int TAG_LSB    = INDEX_LSB + DEF_INDEX_BITS;

    localparam int WORD_BITS  = 32;
    localparam int BLOCK_BITS = 64;
    localparam int NUM_WAYS   = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_MISS = 2'd1,
        ST_WR      = 2'd2
    } state_t;

    function automatic logic [WORD_BITS-1:0] select_word(input logic [BLOCK_BITS-1:0] block,
                                                         input logic offset);
        return offset ? block[63:32] : block[31:0];
    endfunction

endpackage

// File: rtl/cache_memory.sv
// Two-way set storage: valid/tag/data arrays plus one LRU bit per set, with a
// combinational lookup and synchronous fill, word-update and LRU ports.
module cache_memory
    import cache_controller_pkg::*;
#(
    parameter int INDEX_BITS = DEF_INDEX_BITS,
    parameter int TAG_BITS   = DEF_TAG_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] index,
    input  logic [TAG_BITS-1:0]   tag,
    input  logic                  offset,
    output logic                  hit,
    output logic                  hit_way,
    output logic [WORD_BITS-1:0]  hit_word,
    output logic                  victim_way,
    input  logic                  fill_en,
    input  logic                  fill_way,
    input  logic [BLOCK_BITS-1:0] fill_data,
    input  logic                  upd_en,
    input  logic                  upd_way,
    input  logic [WORD_BITS-1:0]  upd_word,
    input  logic                  lru_en,
    input  logic                  lru_way
);

    localparam int NUM_SETS = 1 << INDEX_BITS;

    logic [NUM_SETS-1:0]   valid_q [NUM_WAYS];
    logic [NUM_SETS-1:0]   lru_q;
    logic [TAG_BITS-1:0]   tag_q   [NUM_WAYS][NUM_SETS];
    logic [BLOCK_BITS-1:0] data_q  [NUM_WAYS][NUM_SETS];
    logic [NUM_WAYS-1:0]   way_hit;

    always_comb begin
        for (int w = 0; w < NUM_WAYS; w++) begin
            way_hit[w] = valid_q[w][index] && (tag_q[w][index] == tag);
        end
    end

    // A block is only ever filled on a miss, so at most one way can match.
    assign hit      = |way_hit;
    assign hit_way  = way_hit[1];
    assign hit_word = select_word(data_q[hit_way][index], offset);

    always_comb begin
        if (!valid_q[0][index]) begin
            victim_way = 1'b0;
        end else if (!valid_q[1][index]) begin
            victim_way = 1'b1;
        end else begin
            victim_way = lru_q[index];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                valid_q[w] <= '0;
            end
            lru_q <= '0;
        end else begin
            if (fill_en) begin
                valid_q[fill_way][index] <= 1'b1;
            end
            if (lru_en) begin
                lru_q[index] <= ~lru_way;
            end
        end
    end

    // NOTE: tag and data arrays carry no reset; the valid bits alone decide
    // whether their contents mean anything, which keeps them plain RAM.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[fill_way][index]  <= tag;
            data_q[fill_way][index] <= fill_data;
        end else if (upd_en) begin
            if (offset) begin
                data_q[upd_way][index][63:32] <= upd_word;
            end else begin
                data_q[upd_way][index][31:0] <= upd_word;
            end
        end
    end

endmodule

// File: rtl/cache_controller.sv
// Two-way set-associative, write-through, no-write-allocate read cache between
// the MEM stage and the SRAM controller; holds the FSM and SRAM handshake.
module cache_controller
    import cache_controller_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = DEF_BASE_ADDR,
    parameter int          INDEX_BITS = DEF_INDEX_BITS,
    parameter int          TAG_BITS   = DEF_TAG_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_en,
    input  logic                  wr_en,
    input  logic [31:0]           address,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    output logic                  ready,
    output logic                  sram_rd_en,
    output logic                  sram_wr_en,
    output logic [31:0]           sram_address,
    output logic [31:0]           sram_wdata,
    input  logic [BLOCK_BITS-1:0] sram_rdata,
    input  logic                  sram_ready
);

    localparam int TAG_POS = INDEX_LSB + INDEX_BITS;

    state_t state_q, state_d;

    logic [31:0]           a;
    logic                  offset;
    logic [INDEX_BITS-1:0] index;
    logic [TAG_BITS-1:0]   tag;
    logic                  addr_unused;

    logic                  hit, hit_way, victim_way;
    logic [WORD_BITS-1:0]  hit_word;
    logic                  fill_en, upd_en, lru_en, lru_way;

    assign a           = address - BASE_ADDR;
    assign offset      = a[OFFSET_BIT];
    assign index       = a[INDEX_LSB +: INDEX_BITS];
    assign tag         = a[TAG_POS +: TAG_BITS];
    assign addr_unused = ^{a[31:TAG_POS+TAG_BITS], a[OFFSET_BIT-1:0]};

    assign sram_address = address;
    assign sram_wdata   = wdata;

    cache_memory #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_mem (
        .clk        (clk),
        .rst        (rst),
        .index      (index),
        .tag        (tag),
        .offset     (offset),
        .hit        (hit),
        .hit_way    (hit_way),
        .hit_word   (hit_word),
        .victim_way (victim_way),
        .fill_en    (fill_en),
        .fill_way   (victim_way),
        .fill_data  (sram_rdata),
        .upd_en     (upd_en),
        .upd_way    (hit_way),
        .upd_word   (wdata),
        .lru_en     (lru_en),
        .lru_way    (lru_way)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        ready      = 1'b1;
        rdata      = '0;
        sram_rd_en = 1'b0;
        sram_wr_en = 1'b0;
        fill_en    = 1'b0;
        upd_en     = 1'b0;
        lru_en     = 1'b0;
        lru_way    = hit_way;
        // Reset is synchronous, so the registered state may still be busy
        // during the reset cycle; hold the quiet output values regardless.
        if (!rst) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (wr_en) begin
                        ready   = 1'b0;
                        state_d = ST_WR;
                    end else if (rd_en) begin
                        if (hit) begin
                            rdata  = hit_word;
                            lru_en = 1'b1;
                        end else begin
                            ready   = 1'b0;
                            state_d = ST_RD_MISS;
                        end
                    end
                end
                ST_RD_MISS: begin
                    sram_rd_en = 1'b1;
                    ready      = sram_ready;
                    if (sram_ready) begin
                        rdata   = select_word(sram_rdata, offset);
                        fill_en = 1'b1;
                        lru_en  = 1'b1;
                        lru_way = victim_way;
                        state_d = ST_IDLE;
                    end
                end
                ST_WR: begin
                    sram_wr_en = 1'b1;
                    ready      = sram_ready;
                    if (sram_ready) begin
                        upd_en  = hit;
                        lru_en  = hit;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller: directed scenarios then random
// traffic, compared against a recency-list cache model over a word memory.
module tb_cache_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en, wr_en;
    logic [31:0] address, wdata, rdata;
    logic        ready, sram_rd_en, sram_wr_en;
    logic [31:0] sram_address, sram_wdata;
    logic [63:0] sram_rdata;
    logic        sram_ready;

    int checks = 0;
    int errors = 0;

    // Model: backing memory by word address, and per set the resident block
    // numbers ordered most recently used first.
    bit [31:0]   mem [int unsigned];
    int unsigned res [64][$];

    cache_controller dut (
        .clk          (clk),
        .rst          (rst),
        .rd_en        (rd_en),
        .wr_en        (wr_en),
        .address      (address),
        .wdata        (wdata),
        .rdata        (rdata),
        .ready        (ready),
        .sram_rd_en   (sram_rd_en),
        .sram_wr_en   (sram_wr_en),
        .sram_address (sram_address),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata),
        .sram_ready   (sram_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, observed, expected);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] addr);
        int unsigned k;
        k = addr >> 2;
        if (mem.exists(k)) return mem[k];
        return (addr * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    function automatic int unsigned blk_of(input logic [31:0] addr);
        return ((addr - 32'd1024) >> 3) & 32'hFFFF;
    endfunction

    function automatic bit in_cache(input int unsigned blk);
        int unsigned s;
        s = blk % 64;
        foreach (res[s][i]) if (res[s][i] == blk) return 1'b1;
        return 1'b0;
    endfunction

    task automatic touch(input int unsigned blk);
        int unsigned s;
        s = blk % 64;
        for (int i = 0; i < res[s].size(); i++) begin
            if (res[s][i] == blk) begin
                res[s].delete(i);
                break;
            end
        end
        res[s].push_front(blk);
    endtask

    task automatic fill(input int unsigned blk);
        int unsigned s;
        s = blk % 64;
        if (res[s].size() == 2) void'(res[s].pop_back());
        res[s].push_front(blk);
    endtask

    task automatic clear_model();
        foreach (res[s]) res[s].delete();
    endtask

    // One MEM-stage request: drive it, check the stall/handshake each cycle,
    // answer from the SRAM side after `lat` waiting cycles, update the model.
    task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] data, input int lat);
        int unsigned blk;
        bit          hit;
        logic [31:0] base;
        blk  = blk_of(addr);
        hit  = in_cache(blk);
        base = addr & ~32'h7;
        @(negedge clk);
        rd_en = rd; wr_en = wr; address = addr; wdata = data; sram_ready = 1'b0;
        #1;
        if (!rd && !wr) begin
            check("idle_ready", ready, 1);
            check("idle_rdata", rdata, 0);
            check("idle_sram_rd_en", sram_rd_en, 0);
            check("idle_sram_wr_en", sram_wr_en, 0);
        end else if (wr) begin
            check("wr_req_ready", ready, 0);
            check("wr_req_sram_rd_en", sram_rd_en, 0);
            for (int c = 0; c < lat; c++) begin
                @(negedge clk); #1;
                check("wr_stall_ready", ready, 0);
                check("wr_stall_sram_wr_en", sram_wr_en, 1);
                check("wr_stall_sram_rd_en", sram_rd_en, 0);
                check("wr_sram_address", sram_address, addr);
                check("wr_sram_wdata", sram_wdata, data);
            end
            @(negedge clk);
            sram_ready = 1'b1;
            #1;
            check("wr_done_ready", ready, 1);
            check("wr_done_sram_wr_en", sram_wr_en, 1);
            mem[addr >> 2] = data;
            if (hit) touch(blk);
        end else if (hit) begin
            check("rd_hit_ready", ready, 1);
            check("rd_hit_rdata", rdata, mem_rd(addr));
            check("rd_hit_sram_rd_en", sram_rd_en, 0);
            touch(blk);
        end else begin
            check("rd_miss_ready", ready, 0);
            for (int c = 0; c < lat; c++) begin
                @(negedge clk); #1;
                check("rd_stall_ready", ready, 0);
                check("rd_stall_sram_rd_en", sram_rd_en, 1);
                check("rd_sram_address", sram_address, addr);
            end
            @(negedge clk);
            sram_ready = 1'b1;
            sram_rdata = {mem_rd(base + 32'd4), mem_rd(base)};
            #1;
            check("rd_fill_ready", ready, 1);
            check("rd_fill_rdata", rdata, mem_rd(addr));
            check("rd_fill_sram_rd_en", sram_rd_en, 1);
            fill(blk);
        end
    endtask

    initial begin
        rst = 1'b1; rd_en = 1'b1; wr_en = 1'b0;
        address = 32'd1024; wdata = '0; sram_rdata = '0; sram_ready = 1'b0;
        mem[32'd1024 >> 2] = 32'h0000_0011;
        mem[32'd1028 >> 2] = 32'h0000_0022;

        @(negedge clk); #1;
        check("reset_ready", ready, 1);
        check("reset_sram_rd_en", sram_rd_en, 0);
        check("reset_sram_wr_en", sram_wr_en, 0);
        check("reset_rdata", rdata, 0);
        @(negedge clk);
        rst = 1'b0; rd_en = 1'b0;

        // Cold miss, then a zero-latency hit on the other word of the block.
        access(1, 0, 32'd1024, 32'd0, 5);
        check("cold_rdata_word0", rdata, 32'h11);
        access(1, 0, 32'd1028, 32'd0, 0);
        check("cold_hit_word1", rdata, 32'h22);

        // Fill both ways of set 0, refresh one, then force LRU eviction.
        access(1, 0, 32'd1536, 32'd0, 2);
        access(1, 0, 32'd1024, 32'd0, 0);
        access(1, 0, 32'd2048, 32'd0, 1);
        access(1, 0, 32'd1024, 32'd0, 0);
        access(1, 0, 32'd1536, 32'd0, 3);

        // Write hit updates the cached word.
        access(0, 1, 32'd1028, 32'hDEAD_BEEF, 3);
        access(1, 0, 32'd1028, 32'd0, 0);
        check("write_hit_readback", rdata, 32'hDEAD_BEEF);

        // Write miss does not allocate.
        access(0, 1, 32'd4096, 32'h1234_5678, 2);
        access(1, 0, 32'd4096, 32'd0, 1);

        // Simultaneous read and write is a write.
        access(1, 1, 32'd1024, 32'hA5A5_0001, 2);
        access(1, 0, 32'd1024, 32'd0, 1);

        // Reset two cycles into a read miss abandons the fill.
        @(negedge clk);
        rd_en = 1'b1; wr_en = 1'b0; address = 32'd1104; sram_ready = 1'b0;
        #1; check("rstmiss_req_ready", ready, 0);
        @(negedge clk); #1; check("rstmiss_c1_sram_rd_en", sram_rd_en, 1);
        @(negedge clk); #1; check("rstmiss_c2_sram_rd_en", sram_rd_en, 1);
        rst = 1'b1; sram_ready = 1'b1; sram_rdata = 64'hFFFF_0000_FFFF_0000;
        #1;
        check("rstmiss_in_reset_ready", ready, 1);
        check("rstmiss_in_reset_sram_rd_en", sram_rd_en, 0);
        check("rstmiss_in_reset_rdata", rdata, 0);
        @(negedge clk);
        rst = 1'b0; rd_en = 1'b0; sram_ready = 1'b0;
        #1;
        check("rstmiss_after_ready", ready, 1);
        check("rstmiss_after_sram_rd_en", sram_rd_en, 0);
        clear_model();
        access(1, 0, 32'd1104, 32'd0, 2);
        access(1, 0, 32'd1024, 32'd0, 1);

        // Random traffic over a small pool so hits, misses and evictions mix.
        for (int n = 0; n < 200; n++) begin
            int unsigned op;
            logic [31:0] addr;
            op   = $urandom_range(0, 9);
            addr = 32'd1024 + 32'($urandom_range(0, 3)) * 8 + 32'($urandom_range(0, 3)) * 512
                   + 32'($urandom_range(0, 1)) * 4;
            if (op <= 5)      access(1, 0, addr, 32'd0, $urandom_range(0, 3));
            else if (op <= 7) access(0, 1, addr, $urandom, $urandom_range(0, 3));
            else if (op == 8) access(1, 1, addr, $urandom, $urandom_range(0, 3));
            else              access(0, 0, addr, 32'd0, 0);
        end
        access(0, 0, 32'd1024, 32'd0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
